// File: rtl/decodificador_secuencial_if.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_secuencial_if
// Brief    : Load/mode/output bundle for the sequential one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface decodificador_secuencial_if #(
    parameter int ANCHO      = 2,
    parameter int PERM_ANCHO = 8
);
    localparam int SALIDAS = 1 << ANCHO;

    logic                  Enable;
    logic [1:0]            Modo;
    logic [ANCHO-1:0]      Entrada;
    logic                  Valido;
    logic                  Listo;
    logic [PERM_ANCHO-1:0] Permanencia;
    logic [SALIDAS-1:0]    Salida;
    logic [ANCHO-1:0]      Indice;
    logic                  Activo;

    modport master (
        output Enable, Modo, Entrada, Valido, Permanencia,
        input  Listo, Salida, Indice, Activo
    );

    modport slave (
        input  Enable, Modo, Entrada, Valido, Permanencia,
        output Listo, Salida, Indice, Activo
    );
endinterface
`default_nettype wire

// File: rtl/decodificador_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_secuencial
// Brief    : Registered N-to-2^N one-hot decoder with hold, pulse and scan modes.
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_secuencial #(
    parameter int ANCHO      = 2,
    parameter int PERM_ANCHO = 8
) (
    input  wire                          Reloj,
    input  wire                          Reset_n,
    decodificador_secuencial_if.slave    bus
);
    localparam int SALIDAS = 1 << ANCHO;

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] SOSTENER = 2'd1;
    localparam logic [1:0] PULSO    = 2'd2;
    localparam logic [1:0] BARRIDO  = 2'd3;

    localparam logic [ANCHO-1:0]      INDICE_MAX = {ANCHO{1'b1}};
    localparam logic [PERM_ANCHO-1:0] CONT_UNO   = {{(PERM_ANCHO-1){1'b0}}, 1'b1};
    localparam logic [SALIDAS-1:0]    UNO_CALIENTE_BASE = {{(SALIDAS-1){1'b0}}, 1'b1};

    logic [1:0]            estado;
    logic [1:0]            estado_sig;
    logic [ANCHO-1:0]      indice;
    logic [ANCHO-1:0]      indice_sig;
    logic [PERM_ANCHO-1:0] contador;
    logic [PERM_ANCHO-1:0] contador_sig;
    logic [SALIDAS-1:0]    salida;
    logic [SALIDAS-1:0]    salida_sig;
    logic                  activo;

    logic [PERM_ANCHO-1:0] perm_efectiva;
    logic                  cargable;
    logic                  listo;
    logic                  aceptar;
    logic                  ultimo_ciclo;

    // A zero dwell is clamped to one so the counter can never underflow.
    assign perm_efectiva = (bus.Permanencia == '0) ? CONT_UNO : bus.Permanencia;

    assign cargable     = (estado == REPOSO) || (estado == SOSTENER);
    assign listo        = Reset_n && bus.Enable && cargable;
    assign aceptar      = bus.Valido && listo;
    assign ultimo_ciclo = (contador <= CONT_UNO);

    always_comb begin
        estado_sig   = estado;
        indice_sig   = indice;
        contador_sig = contador;

        if (!bus.Enable) begin
            estado_sig   = REPOSO;
            contador_sig = '0;
        end else begin
            case (estado)
                REPOSO, SOSTENER: begin
                    // Scan request wins over a load and needs no Valido.
                    if (bus.Modo[1]) begin
                        estado_sig   = BARRIDO;
                        indice_sig   = bus.Modo[0] ? INDICE_MAX : '0;
                        contador_sig = perm_efectiva;
                    end else if (aceptar) begin
                        indice_sig = bus.Entrada;
                        if (bus.Modo[0]) begin
                            estado_sig   = PULSO;
                            contador_sig = perm_efectiva;
                        end else begin
                            estado_sig   = SOSTENER;
                            contador_sig = '0;
                        end
                    end
                end

                PULSO: begin
                    if (ultimo_ciclo) begin
                        estado_sig   = REPOSO;
                        contador_sig = '0;
                    end else begin
                        contador_sig = contador - CONT_UNO;
                    end
                end

                BARRIDO: begin
                    if (!bus.Modo[1]) begin
                        estado_sig   = REPOSO;
                        contador_sig = '0;
                    end else if (ultimo_ciclo) begin
                        // Direction is read at the step, so 10<->11 reverses without reload of Indice.
                        indice_sig   = bus.Modo[0] ? (indice - 1'b1) : (indice + 1'b1);
                        contador_sig = perm_efectiva;
                    end else begin
                        contador_sig = contador - CONT_UNO;
                    end
                end

                default: begin
                    estado_sig   = REPOSO;
                    contador_sig = '0;
                end
            endcase
        end
    end

    // Output is decoded from the next-state values so Salida sits directly on a flop.
    always_comb begin
        salida_sig = '0;
        if (estado_sig != REPOSO) begin
            salida_sig = UNO_CALIENTE_BASE << indice_sig;
        end
    end

    always_ff @(posedge Reloj) begin
        if (!Reset_n) begin
            estado   <= REPOSO;
            indice   <= '0;
            contador <= '0;
            salida   <= '0;
            activo   <= 1'b0;
        end else begin
            estado   <= estado_sig;
            indice   <= indice_sig;
            contador <= contador_sig;
            salida   <= salida_sig;
            activo   <= (estado_sig != REPOSO);
        end
    end

    assign bus.Listo  = listo;
    assign bus.Salida = salida;
    assign bus.Indice = indice;
    assign bus.Activo = activo;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_decodificador_secuencial
// Brief    : Directed self-checking bench for decodificador_secuencial (ANCHO=2 and ANCHO=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decodificador_secuencial;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    decodificador_secuencial_if #(.ANCHO(2), .PERM_ANCHO(8)) bus_a ();
    decodificador_secuencial_if #(.ANCHO(3), .PERM_ANCHO(8)) bus_b ();

    decodificador_secuencial #(.ANCHO(2), .PERM_ANCHO(8)) dut_a (
        .Reloj   (clk),
        .Reset_n (rst_n),
        .bus     (bus_a.slave)
    );

    decodificador_secuencial #(.ANCHO(3), .PERM_ANCHO(8)) dut_b (
        .Reloj   (clk),
        .Reset_n (rst_n),
        .bus     (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] scan_exp [9];
    logic [2:0] idx_b;

    initial begin
        checks = 0;
        errors = 0;
        scan_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                     4'b0100, 4'b1000, 4'b1000, 4'b0001};

        rst_n = 1'b0;
        bus_a.Enable = 1'b1; bus_a.Modo = 2'b00; bus_a.Entrada = 2'd2;
        bus_a.Valido = 1'b1; bus_a.Permanencia = 8'd0;
        bus_b.Enable = 1'b0; bus_b.Modo = 2'b00; bus_b.Entrada = 3'd0;
        bus_b.Valido = 1'b0; bus_b.Permanencia = 8'd1;

        // Reset
        repeat (3) tick();
        check("rst_salida", 32'(bus_a.Salida), 32'h0);
        check("rst_indice", 32'(bus_a.Indice), 32'h0);
        check("rst_listo",  32'(bus_a.Listo),  32'h0);
        check("rst_activo", 32'(bus_a.Activo), 32'h0);
        rst_n = 1'b1;
        bus_a.Valido = 1'b0;
        #1;
        check("post_rst_listo", 32'(bus_a.Listo), 32'h1);
        tick();

        // Hold
        bus_a.Modo = 2'b00; bus_a.Entrada = 2'd2; bus_a.Valido = 1'b1;
        tick();
        bus_a.Valido = 1'b0;
        check("hold_indice", 32'(bus_a.Indice), 32'd2);
        check("hold_activo", 32'(bus_a.Activo), 32'h1);
        check("hold_listo",  32'(bus_a.Listo),  32'h1);
        for (int i = 0; i < 20; i++) begin
            check("hold_salida", 32'(bus_a.Salida), 32'b0100);
            tick();
        end
        bus_a.Entrada = 2'd3; bus_a.Valido = 1'b1;
        tick();
        check("hold_reload", 32'(bus_a.Salida), 32'b1000);
        bus_a.Entrada = 2'd0;
        tick();
        check("b2b_0", 32'(bus_a.Salida), 32'b0001);
        bus_a.Entrada = 2'd1;
        tick();
        check("b2b_1", 32'(bus_a.Salida), 32'b0010);
        bus_a.Valido = 1'b0;

        // Pulse of 4, with Valido left high and a different Entrada
        bus_a.Modo = 2'b01; bus_a.Entrada = 2'd1; bus_a.Permanencia = 8'd4; bus_a.Valido = 1'b1;
        tick();
        bus_a.Entrada = 2'd3;
        for (int i = 0; i < 4; i++) begin
            check("pulse_salida", 32'(bus_a.Salida), 32'b0010);
            check("pulse_listo",  32'(bus_a.Listo),  32'h0);
            tick();
        end
        check("pulse_end_salida", 32'(bus_a.Salida), 32'h0);
        check("pulse_end_listo",  32'(bus_a.Listo),  32'h1);
        bus_a.Valido = 1'b0;
        tick();

        // Pulse with Permanencia=0 lasts one cycle
        bus_a.Entrada = 2'd1; bus_a.Permanencia = 8'd0; bus_a.Valido = 1'b1;
        tick();
        bus_a.Valido = 1'b0;
        check("pulse0_on", 32'(bus_a.Salida), 32'b0010);
        tick();
        check("pulse0_off", 32'(bus_a.Salida), 32'h0);

        // Ascending scan, then reverse
        bus_a.Modo = 2'b10; bus_a.Permanencia = 8'd2;
        tick();
        for (int i = 0; i < 9; i++) begin
            check("scan_up", 32'(bus_a.Salida), 32'(scan_exp[i]));
            tick();
        end
        check("scan_pre_rev", 32'(bus_a.Salida), 32'b0001);
        bus_a.Modo = 2'b11;
        tick();
        check("scan_rev_0", 32'(bus_a.Salida), 32'b1000);
        check("scan_rev_idx", 32'(bus_a.Indice), 32'd3);
        tick();
        check("scan_rev_1", 32'(bus_a.Salida), 32'b1000);
        tick();
        check("scan_rev_2", 32'(bus_a.Salida), 32'b0100);
        bus_a.Modo = 2'b00;
        tick();
        check("scan_exit", 32'(bus_a.Salida), 32'h0);

        // Enable abort mid-pulse
        bus_a.Modo = 2'b01; bus_a.Entrada = 2'd2; bus_a.Permanencia = 8'd10; bus_a.Valido = 1'b1;
        tick();
        bus_a.Valido = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("abort_pre", 32'(bus_a.Salida), 32'b0100);
            tick();
        end
        check("abort_pre", 32'(bus_a.Salida), 32'b0100);
        bus_a.Enable = 1'b0;
        tick();
        check("abort_salida", 32'(bus_a.Salida), 32'h0);
        check("abort_activo", 32'(bus_a.Activo), 32'h0);
        check("abort_listo",  32'(bus_a.Listo),  32'h0);
        bus_a.Enable = 1'b1; bus_a.Modo = 2'b00;
        tick();
        tick();
        check("reenable_salida", 32'(bus_a.Salida), 32'h0);
        check("reenable_listo",  32'(bus_a.Listo),  32'h1);

        // Enable drop on the last dwell cycle: no step
        bus_a.Modo = 2'b10; bus_a.Permanencia = 8'd1;
        tick();
        check("edge_scan_idx", 32'(bus_a.Indice), 32'd0);
        bus_a.Enable = 1'b0;
        tick();
        check("edge_salida", 32'(bus_a.Salida), 32'h0);
        check("edge_no_step", 32'(bus_a.Indice), 32'd0);
        bus_a.Modo = 2'b00;
        bus_a.Enable = 1'b1;

        // ANCHO=3 descending scan with single-cycle dwell
        bus_b.Enable = 1'b1; bus_b.Modo = 2'b11; bus_b.Permanencia = 8'd1;
        tick();
        idx_b = 3'd7;
        for (int i = 0; i < 9; i++) begin
            check("w3_indice", 32'(bus_b.Indice), 32'(idx_b));
            check("w3_salida", 32'(bus_b.Salida), 32'h1 << idx_b);
            idx_b = idx_b - 3'd1;
            tick();
        end

        // Reset mid-scan aborts at once
        rst_n = 1'b0;
        tick();
        check("rst_scan_salida", 32'(bus_b.Salida), 32'h0);
        check("rst_scan_indice", 32'(bus_b.Indice), 32'h0);
        check("rst_scan_listo",  32'(bus_b.Listo),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decodificador_secuencial.md
# decodificador_secuencial

Registered, parametrised N-to-2^N one-hot decoder with handshake loading and three operating modes: hold, timed pulse and automatic scan. It is the sequential successor of the combinational 2-to-4 decoder. It drives select or strobe lines such as display digit enables, row scanning and chip selects directly from a flop. Cascading decoders through enables is no longer needed because the width is a parameter.

## Interface
- ANCHO, 2, select code width; output width is 2^ANCHO (ANCHO ≥ 1).
- PERM_ANCHO, 8, width of the dwell/pulse length input and internal counter.

- Reloj  in  1  single clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Enable  in  1  global enable; low forces return to REPOSO.
- Modo  in  2  00 sostener, 01 pulso, 10 barrido ascendente, 11 barrido descendente.
- Entrada  in  ANCHO  code to decode, sampled on accept.
- Valido  in  1  Entrada/Modo valid for load (modes 00/01).
- Listo  out  1  block can accept a load this cycle.
- Permanencia  in  PERM_ANCHO  cycles per pulse / per scan step; 0 treated as 1.
- Salida  out  2^ANCHO  registered one-hot output, all-zero when idle.
- Indice  out  ANCHO  code currently decoded.
- Activo  out  1  high when Salida is non-zero.

## Operation
- Accept = Valido & Listo.
- Listo = Reset_n & Enable & (state is REPOSO or SOSTENER).
- States:
  - REPOSO: Salida=0, Activo=0.
  - SOSTENER: Salida=onehot(Indice) held indefinitely.
  - PULSO: Salida=onehot(Indice) for a fixed count.
  - BARRIDO: Salida=onehot(Indice), stepping automatically.
- From REPOSO or SOSTENER, with Enable=1:
  - Modo[1]=1 (no Valido needed): go to BARRIDO. Indice=0 for Modo 10, Indice=2^ANCHO−1 for Modo 11. Dwell counter loads max(Permanencia,1).
  - Accept with Modo=00: go to SOSTENER, Indice=Entrada.
  - Accept with Modo=01: go to PULSO, Indice=Entrada, counter loads max(Permanencia,1).
  - SOSTENER with no accept and Modo[1]=0: stay, Salida unchanged.
- PULSO:
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, the next state is REPOSO. Salida is therefore high for exactly max(Permanencia,1) cycles.
  - Valido is ignored (Listo=0).
- BARRIDO:
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, Indice steps ±1 modulo 2^ANCHO (wraps 3→0 ascending, 0→3 descending for ANCHO=2). The counter reloads max(Permanencia,1), with Permanencia sampled at that step.
  - If Modo[1] goes to 0: REPOSO next cycle.
  - A change between 10 and 11 reverses direction at the next step without resetting Indice.
- Enable=0 in any state: next state REPOSO, Salida=0, counter cleared. Enable has priority over accept and over step.
- Salida is always exactly one-hot or all-zero, and always consistent with Indice and the state.
- Arithmetic: Indice wraps naturally in ANCHO bits. The counter never underflows, because 0 is clamped to 1 at load.

## Timing
- Reset (Reset_n low at a rising edge): state=REPOSO, Salida=0, Indice=0, Activo=0, counter=0. Listo=0 while Reset_n is low.
- Reset mid-pulse or mid-scan aborts immediately: outputs are zero after that edge.
- Latency: accept on edge k gives Salida/Indice/Activo updated after edge k (visible in cycle k+1). There is no combinational path from Entrada to Salida.
- Listo is combinational from state, Enable and Reset_n. Valido may stay high. Back-to-back loads in SOSTENER are accepted every cycle.
- Pulse of P cycles (P≥1): Salida high during cycles k+1 … k+P. Listo rises in cycle k+P+1.
- Scan: each Indice value is held max(Permanencia,1) cycles. A full ascending cycle of 2^ANCHO values takes 2^ANCHO·max(P,1) cycles.
- Simultaneous Enable=0 and the last pulse/step cycle: result is REPOSO; no step occurs.

## Test plan
- Reset: ANCHO=2, hold Reset_n=0 for 3 cycles with Valido=1, Enable=1 -> Salida=0000, Indice=0, Listo=0. After release, Listo=1.
- Hold mode: Modo=00, Entrada=2, one-cycle Valido -> next cycle Salida=0100, Indice=2, held for 20 cycles. Then Entrada=3 with Valido -> Salida=1000 one cycle later.
- Pulse: Modo=01, Entrada=1, Permanencia=4 -> Salida=0010 for exactly 4 cycles, then 0000. Listo=0 throughout and Valido ignored. Repeat with Permanencia=0 -> 1-cycle pulse.
- Scan ascending: Modo=10, Permanencia=2 -> Salida sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001 (wrap). Switch to Modo=11 mid-run -> direction reverses at the next step.
- Enable abort: start a scan or a Permanencia=10 pulse, then drop Enable at cycle 3 -> Salida=0000 the next cycle, state REPOSO. Raising Enable with Modo=00 and no Valido keeps Salida=0.
- Parametrisation: ANCHO=3, Modo=11, Permanencia=1 -> Indice 7,6,…,0,7 on successive cycles, with Salida always one-hot of width 8.
